// File: rtl/cache_refill_unit.sv
// rtl/cache_refill_unit.sv - critical-word-first line refill engine
// Takes one miss, issues wrapped single-word reads, returns indexed fill beats.
module cache_refill_unit #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int LINE_WORDS      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_valid,
  output logic                          miss_ready,
  input  logic [ADDR_W-1:0]             miss_addr,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_W-1:0]             mem_req_addr,
  input  logic                          mem_resp_valid,
  input  logic [DATA_W-1:0]             mem_resp_data,
  input  logic                          mem_resp_err,
  output logic                          fill_valid,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic [DATA_W-1:0]             fill_data,
  output logic                          fill_err,
  output logic                          fill_last,
  output logic                          busy
);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + 2;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);
  localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [IDX_W-1:0]    start_idx_q, start_idx_d;
  logic [IDX_W-1:0]    req_cnt_q, req_cnt_d;
  logic [IDX_W-1:0]    resp_cnt_q, resp_cnt_d;
  logic [OUT_W-1:0]    outstanding_q, outstanding_d;
  logic                miss_ready_q, miss_ready_d;
  logic                busy_q, busy_d;
  logic                req_valid_q, req_valid_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic                fill_valid_q, fill_valid_d;
  logic [IDX_W-1:0]    fill_idx_q, fill_idx_d;
  logic [DATA_W-1:0]   fill_data_q, fill_data_d;
  logic                fill_err_q, fill_err_d;
  logic                fill_last_q, fill_last_d;

  logic req_hs;
  logic resp_take;
  logic unused_addr_bits;

  // Byte offset within a word never reaches the bus: requests are word aligned.
  assign unused_addr_bits = &{1'b0, miss_addr[1:0]};

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [IDX_W-1:0]  idx);
    return b | {{(ADDR_W-OFF_W){1'b0}}, idx, 2'b00};
  endfunction

  assign req_hs    = req_valid_q && mem_req_ready;
  // A response with nothing in flight cannot belong to this line, so it is dropped.
  assign resp_take = mem_resp_valid && (state_q != IDLE) && (outstanding_q != '0);

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    start_idx_d   = start_idx_q;
    req_cnt_d     = req_cnt_q;
    resp_cnt_d    = resp_cnt_q;
    outstanding_d = outstanding_q;
    fill_valid_d  = 1'b0;
    fill_idx_d    = fill_idx_q;
    fill_data_d   = fill_data_q;
    fill_err_d    = 1'b0;
    fill_last_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_valid) begin
          state_d       = ISSUE;
          base_d        = {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          start_idx_d   = miss_addr[OFF_W-1:2];
          req_cnt_d     = '0;
          resp_cnt_d    = '0;
          outstanding_d = '0;
        end
      end
      ISSUE: begin
        if (req_hs && (req_cnt_q == LAST_IDX)) state_d = DRAIN;
      end
      DRAIN: begin
        if (resp_take && (resp_cnt_q == LAST_IDX)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (req_hs) req_cnt_d = req_cnt_q + IDX_W'(1);

    if (req_hs && !resp_take)      outstanding_d = outstanding_q + OUT_W'(1);
    else if (!req_hs && resp_take) outstanding_d = outstanding_q - OUT_W'(1);

    if (resp_take) begin
      fill_valid_d = 1'b1;
      fill_idx_d   = start_idx_q + resp_cnt_q;
      fill_data_d  = mem_resp_data;
      fill_err_d   = mem_resp_err;
      fill_last_d  = (resp_cnt_q == LAST_IDX);
      resp_cnt_d   = resp_cnt_q + IDX_W'(1);
    end

    // Request valid/address are computed from next-state values so they are flops.
    miss_ready_d = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    req_valid_d  = (state_d == ISSUE) && (outstanding_d < MAX_OUT);
    req_addr_d   = word_addr(base_d, start_idx_d + req_cnt_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      start_idx_q   <= '0;
      req_cnt_q     <= '0;
      resp_cnt_q    <= '0;
      outstanding_q <= '0;
      miss_ready_q  <= 1'b1;
      busy_q        <= 1'b0;
      req_valid_q   <= 1'b0;
      req_addr_q    <= '0;
      fill_valid_q  <= 1'b0;
      fill_idx_q    <= '0;
      fill_data_q   <= '0;
      fill_err_q    <= 1'b0;
      fill_last_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      start_idx_q   <= start_idx_d;
      req_cnt_q     <= req_cnt_d;
      resp_cnt_q    <= resp_cnt_d;
      outstanding_q <= outstanding_d;
      miss_ready_q  <= miss_ready_d;
      busy_q        <= busy_d;
      req_valid_q   <= req_valid_d;
      req_addr_q    <= req_addr_d;
      fill_valid_q  <= fill_valid_d;
      fill_idx_q    <= fill_idx_d;
      fill_data_q   <= fill_data_d;
      fill_err_q    <= fill_err_d;
      fill_last_q   <= fill_last_d;
    end
  end

  assign miss_ready    = miss_ready_q;
  assign busy          = busy_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign fill_valid    = fill_valid_q;
  assign fill_idx      = fill_idx_q;
  assign fill_data     = fill_data_q;
  assign fill_err      = fill_err_q;
  assign fill_last     = fill_last_q;

endmodule

// File: tb/tb_cache_refill_unit.sv
// tb/tb_cache_refill_unit.sv - scoreboard bench for cache_refill_unit
// Stimulus pushes expected requests/beats; negedge monitors pop and compare.
module tb_cache_refill_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_valid = 1'b0;
  logic        miss_ready;
  logic [31:0] miss_addr = 32'h0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'h0;
  logic        mem_resp_err = 1'b0;
  logic        fill_valid;
  logic [1:0]  fill_idx;
  logic [31:0] fill_data;
  logic        fill_err;
  logic        fill_last;
  logic        busy;

  cache_refill_unit #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
    .fill_valid(fill_valid), .fill_idx(fill_idx), .fill_data(fill_data),
    .fill_err(fill_err), .fill_last(fill_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] data;
    logic        err;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic [31:0] exp_req[$];
  beat_t       exp_fill[$];
  pend_t       pend[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int hs_n = 0, resp_n = 0;
  int hs_edge[64];
  int resp_edge[64];
  int delay_hs = -1, delay_amt = 0, err_resp = -1, rdy_block = 0;
  bit spur = 1'b0;
  int out_m = 0, out_max = 0;
  logic [31:0] bp_addr = 32'h0;
  pend_t p_new;

  // Memory model: in-order responses, driven for the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      mem_resp_valid = 1'b0;
      mem_resp_err   = 1'b0;
      mem_req_ready  = 1'b1;
      out_m          = 0;
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_err   = 1'b0;
      if (spur) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0_BAD0;
        spur           = 1'b0;
      end else if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = data_of(pend[0].addr);
        mem_resp_err   = (resp_n == err_resp);
        if (resp_n < 64) resp_edge[resp_n] = cyc + 1;
        resp_n++;
        out_m--;
        void'(pend.pop_front());
      end
      if (mem_req_valid && rdy_block > 0) begin
        mem_req_ready = 1'b0;
        chk("bp_addr_stable", mem_req_addr, bp_addr);
        rdy_block--;
      end else begin
        mem_req_ready = 1'b1;
      end
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req.size() == 0) begin
          total++; bad++;
          $display("FAIL req_unexpected: got 0x%08h expected no request", mem_req_addr);
        end else begin
          chk("req_addr", mem_req_addr, exp_req.pop_front());
        end
        p_new.addr = mem_req_addr;
        p_new.due  = cyc + 2 + ((hs_n == delay_hs) ? delay_amt : 0);
        pend.push_back(p_new);
        if (hs_n < 64) hs_edge[hs_n] = cyc + 1;
        hs_n++;
        out_m++;
      end
      if (out_m > out_max) out_max = out_m;
    end
  end

  int fill_cnt = 0, last_cnt = 0;
  beat_t e_b;

  always @(negedge clk) begin
    if (!rst && fill_valid) begin
      fill_cnt++;
      if (exp_fill.size() == 0) begin
        total++; bad++;
        $display("FAIL fill_unexpected: got idx=%0d data=0x%08h expected no beat", fill_idx, fill_data);
      end else begin
        e_b = exp_fill.pop_front();
        chk("fill_idx", {30'b0, fill_idx}, {30'b0, e_b.idx});
        chk("fill_data", fill_data, e_b.data);
        chk("fill_err", {31'b0, fill_err}, {31'b0, e_b.err});
        chk("fill_last", {31'b0, fill_last}, {31'b0, e_b.last});
        chk("miss_ready_vs_last", {31'b0, miss_ready}, {31'b0, e_b.last});
      end
      if (fill_last) last_cnt++;
    end
  end

  task automatic beat(input logic [31:0] addr, input logic [1:0] idx, input logic err, input logic last);
    beat_t b;
    exp_req.push_back(addr);
    b.idx = idx; b.data = data_of(addr); b.err = err; b.last = last;
    exp_fill.push_back(b);
  endtask

  task automatic do_miss(input logic [31:0] addr);
    int n = 0;
    @(negedge clk);
    while (!miss_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!miss_ready) begin
      total++; bad++;
      $display("FAIL miss_accept_timeout: got miss_ready=0 expected 1 within 300 cycles");
    end
    miss_valid = 1'b1;
    miss_addr  = addr;
    @(negedge clk);
    miss_valid = 1'b0;
    miss_addr  = 32'h0;
  endtask

  task automatic wait_lines(input int target);
    int n = 0;
    while (last_cnt < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("line_done", last_cnt, target);
    repeat (2) @(negedge clk);
  endtask

  int b_hs, b_fill;

  initial begin
    #12;
    chk("rst_miss_ready", {31'b0, miss_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_fill_valid", {31'b0, fill_valid}, 32'd0);
    chk("rst_fill_last", {31'b0, fill_last}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Aligned miss followed back-to-back by a critical-word-first miss.
    beat(32'h011001F0, 2'd0, 1'b0, 1'b0);
    beat(32'h011001F4, 2'd1, 1'b0, 1'b0);
    beat(32'h011001F8, 2'd2, 1'b0, 1'b0);
    beat(32'h011001FC, 2'd3, 1'b0, 1'b1);
    beat(32'h0AA001F8, 2'd2, 1'b0, 1'b0);
    beat(32'h0AA001FC, 2'd3, 1'b0, 1'b0);
    beat(32'h0AA001F0, 2'd0, 1'b0, 1'b0);
    beat(32'h0AA001F4, 2'd1, 1'b0, 1'b1);
    do_miss(32'h011001F0);
    do_miss(32'h0AA001F8);
    wait_lines(2);

    // Outstanding limit with the first response held back 10 cycles.
    b_hs = hs_n;
    delay_hs = b_hs; delay_amt = 10;
    beat(32'h066001F0, 2'd0, 1'b0, 1'b0);
    beat(32'h066001F4, 2'd1, 1'b0, 1'b0);
    beat(32'h066001F8, 2'd2, 1'b0, 1'b0);
    beat(32'h066001FC, 2'd3, 1'b0, 1'b1);
    do_miss(32'h066001F0);
    wait_lines(3);
    delay_hs = -1;
    chk("limit_two_before_resp", {31'b0, hs_edge[b_hs+1] < resp_edge[b_hs]}, 32'd1);
    chk("limit_third_after_resp", hs_edge[b_hs+2], resp_edge[b_hs] + 1);
    chk("limit_out_max", out_max, 32'd2);

    // Request backpressure on the first request.
    bp_addr = 32'h022001F0;
    rdy_block = 5;
    beat(32'h022001F0, 2'd0, 1'b0, 1'b0);
    beat(32'h022001F4, 2'd1, 1'b0, 1'b0);
    beat(32'h022001F8, 2'd2, 1'b0, 1'b0);
    beat(32'h022001FC, 2'd3, 1'b0, 1'b1);
    do_miss(32'h022001F0);
    wait_lines(4);
    chk("bp_all_stall_cycles", rdy_block, 32'd0);

    // Bus error on the second response.
    err_resp = resp_n + 1;
    beat(32'h033001F0, 2'd0, 1'b0, 1'b0);
    beat(32'h033001F4, 2'd1, 1'b1, 1'b0);
    beat(32'h033001F8, 2'd2, 1'b0, 1'b0);
    beat(32'h033001FC, 2'd3, 1'b0, 1'b1);
    do_miss(32'h033001F0);
    wait_lines(5);
    err_resp = -1;

    // Reset mid-refill.
    b_fill = fill_cnt;
    beat(32'h055001F4, 2'd1, 1'b0, 1'b0);
    beat(32'h055001F8, 2'd2, 1'b0, 1'b0);
    beat(32'h055001FC, 2'd3, 1'b0, 1'b0);
    beat(32'h055001F0, 2'd0, 1'b0, 1'b1);
    do_miss(32'h055001F4);
    for (int n = 0; n < 100 && fill_cnt < b_fill + 2; n++) begin
      @(negedge clk);
      #1;
    end
    chk("rst_after_two_beats", {31'b0, fill_cnt >= b_fill + 2}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_fill_valid", {31'b0, fill_valid}, 32'd0);
    chk("mid_rst_fill_last", {31'b0, fill_last}, 32'd0);
    chk("mid_rst_fill_data", fill_data, 32'd0);
    chk("mid_rst_fill_idx", {30'b0, fill_idx}, 32'd0);
    chk("mid_rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("mid_rst_req_addr", mem_req_addr, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    exp_req.delete();
    exp_fill.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_miss_ready", {31'b0, miss_ready}, 32'd1);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);

    // Spurious response while idle must not produce a beat.
    b_fill = fill_cnt;
    spur = 1'b1;
    repeat (4) @(negedge clk);
    chk("spurious_no_fill", fill_cnt, b_fill);

    beat(32'h044001F0, 2'd0, 1'b0, 1'b0);
    beat(32'h044001F4, 2'd1, 1'b0, 1'b0);
    beat(32'h044001F8, 2'd2, 1'b0, 1'b0);
    beat(32'h044001FC, 2'd3, 1'b0, 1'b1);
    do_miss(32'h044001F0);
    wait_lines(6);

    chk("out_never_above_2", {31'b0, out_max <= 2}, 32'd1);
    chk("req_queue_drained", exp_req.size(), 32'd0);
    chk("fill_queue_drained", exp_fill.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
